// File: rtl/usb_pkg.sv
// Shared USB full-speed definitions: PID codes, PID classes and CRC5 constants.
// Used by usb_fs_rx, usb_fs_tx and the packet relay.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // The two low PID bits select the packet class.
    localparam logic [1:0] PID_CLASS_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
    localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_CLASS_DATA      = 2'b11;

    localparam logic [4:0] CRC5_POLY    = 5'b00101;
    localparam logic [4:0] CRC5_INIT    = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUE = 5'b01100;

    function automatic logic [1:0] pid_class(input logic [3:0] pid);
        return pid[1:0];
    endfunction

endpackage

// File: rtl/usb_crc5.sv
// Combinational USB token CRC5 over an 11-bit field sent LSB first.
// Output is inverted and bit-reversed so crc5[0] is the first CRC bit on the wire.
module usb_crc5
    import usb_pkg::*;
(
    input  logic [10:0] data,
    output logic [4:0]  crc5
);

    logic [4:0] lfsr;

    // NOTE: blocking assignments here because lfsr is a combinational running value
    // updated once per loop iteration; non-blocking would only keep the last step.
    always_comb begin
        lfsr = CRC5_INIT;
        crc5 = '0;
        for (int i = 0; i < 11; i++) begin
            if (data[i] ^ lfsr[4]) begin
                lfsr = {lfsr[3:0], 1'b0} ^ CRC5_POLY;
            end else begin
                lfsr = {lfsr[3:0], 1'b0};
            end
        end
        for (int i = 0; i < 5; i++) begin
            crc5[i] = ~lfsr[4-i];
        end
    end

endmodule

// File: rtl/usb_pkt_relay.sv
// Store-and-forward relay from the usb_fs_rx packet interface to the usb_fs_tx pull interface.
// Buffers one packet, drops bad/short/oversized/overlapping ones, rebuilds token bytes, replays.
module usb_pkt_relay
    import usb_pkg::*;
#(
    parameter int DEPTH = 72,
    parameter int CNT_W = 8
) (
    input  logic             clk_12mhz,
    input  logic             reset,
    input  logic             rx_pkt_start,
    input  logic             rx_pkt_end,
    input  logic             rx_pkt_valid,
    input  logic [3:0]       rx_pid,
    input  logic [6:0]       rx_addr,
    input  logic [3:0]       rx_endp,
    input  logic [10:0]      rx_frame_num,
    input  logic             rx_data_put,
    input  logic [7:0]       rx_data,
    output logic             tx_pkt_start,
    output logic [3:0]       tx_pid,
    output logic             tx_data_avail,
    output logic [7:0]       tx_data,
    input  logic             tx_data_get,
    input  logic             tx_pkt_end,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_LOAD, S_START, S_SEND} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] count;

    logic             is_sof, is_token, is_data, buf_full, get;
    logic [10:0]      crc_in;
    logic [4:0]       crc5;
    logic [7:0]       tok_byte0, tok_byte1;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             drop;

    usb_crc5 u_crc5 (.data(crc_in), .crc5(crc5));

    // NOTE: every signal gets a default at the top of each always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        is_sof    = (rx_pid == PID_SOF);
        is_token  = (pid_class(rx_pid) == PID_CLASS_TOKEN);
        is_data   = (pid_class(rx_pid) == PID_CLASS_DATA);
        buf_full  = (wr_ptr == PTR_W'(DEPTH));
        get       = tx_data_get && tx_data_avail;
        rd_next   = rd_ptr + PTR_W'(1);
        crc_in    = is_sof ? rx_frame_num : {rx_endp, rx_addr};
        tok_byte0 = crc_in[7:0];
        tok_byte1 = {crc5, crc_in[10:8]};
    end

    // Single write port: token byte 0 goes in on the valid end cycle, byte 1 during LOAD.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = rx_data;
        if (state == S_CAPTURE) begin
            if (rx_pkt_end) begin
                wr_en   = rx_pkt_valid && is_token;
                wr_data = tok_byte0;
            end else if (rx_data_put && !buf_full) begin
                wr_en   = 1'b1;
                wr_addr = wr_ptr[IDX_W-1:0];
            end
        end else if (state == S_LOAD && is_token) begin
            wr_en   = 1'b1;
            wr_addr = IDX_W'(1);
            wr_data = tok_byte1;
        end
    end

    always_comb begin
        drop = 1'b0;
        case (state)
            S_IDLE:    drop = 1'b0;
            S_CAPTURE: drop = rx_pkt_start ||
                              (rx_pkt_end ? !rx_pkt_valid : (rx_data_put && buf_full));
            S_LOAD:    drop = rx_pkt_start || (is_data && wr_ptr < PTR_W'(2));
            default:   drop = rx_pkt_start;
        endcase
    end

    // NOTE: packet contents are fully rewritten before being read, so the array carries
    // no reset and can map onto plain RAM.
    always_ff @(posedge clk_12mhz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tx_pkt_start  <= 1'b0;
            tx_pid        <= '0;
            tx_data_avail <= 1'b0;
            tx_data       <= '0;
            drop_count    <= '0;
        end else begin
            tx_pkt_start <= 1'b0;
            if (drop && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (rx_pkt_start) begin
                        wr_ptr <= '0;
                        state  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (rx_pkt_end) begin
                        state <= rx_pkt_valid ? S_LOAD : S_IDLE;
                    end else if (rx_data_put) begin
                        if (buf_full) state <= S_IDLE;
                        else          wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                end
                S_LOAD: begin
                    if (is_data && wr_ptr < PTR_W'(2)) begin
                        state <= S_IDLE;
                    end else begin
                        // Data drops its CRC16 (tx regenerates it); tokens are two rebuilt bytes.
                        if (is_data)       count <= wr_ptr - PTR_W'(2);
                        else if (is_token) count <= PTR_W'(2);
                        else               count <= '0;
                        tx_pid       <= rx_pid;
                        tx_pkt_start <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    rd_ptr        <= '0;
                    tx_data       <= mem[0];
                    tx_data_avail <= (count != '0);
                    state         <= S_SEND;
                end
                S_SEND: begin
                    if (tx_pkt_end) begin
                        tx_data_avail <= 1'b0;
                        state         <= S_IDLE;
                    end else if (get) begin
                        rd_ptr  <= rd_next;
                        tx_data <= mem[rd_next[IDX_W-1:0]];
                        if (rd_next == count) tx_data_avail <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_usb_pkt_relay.sv
// Randomized self-checking bench for usb_pkt_relay against a packet-level reference model.
`timescale 1ns/1ps
module tb_usb_pkt_relay;
    import usb_pkg::*;

    localparam int DEPTH   = 72;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [7:0] byte_q_t [$];

    logic             clk_12mhz = 1'b0;
    logic             reset;
    logic             rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_data_put;
    logic [3:0]       rx_pid;
    logic [6:0]       rx_addr;
    logic [3:0]       rx_endp;
    logic [10:0]      rx_frame_num;
    logic [7:0]       rx_data;
    logic             tx_pkt_start, tx_data_avail, tx_data_get, tx_pkt_end, busy;
    logic [3:0]       tx_pid;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] drop_count;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_drops = 0;

    usb_pkt_relay #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_12mhz(clk_12mhz), .reset(reset),
        .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
        .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_frame_num(rx_frame_num),
        .rx_data_put(rx_data_put), .rx_data(rx_data),
        .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid), .tx_data_avail(tx_data_avail),
        .tx_data(tx_data), .tx_data_get(tx_data_get), .tx_pkt_end(tx_pkt_end),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_12mhz);
        #1;
    endtask

    // USB CRC5 in reflected form: register bit 0 is the first CRC bit transmitted.
    function automatic logic [4:0] crc5_ref(input logic [10:0] f);
        logic [4:0] r;
        logic       fb;
        r = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = f[i] ^ r[0];
            r  = r >> 1;
            if (fb) r = r ^ 5'b10100;
        end
        return ~r;
    endfunction

    function automatic void predict(input logic [3:0] pid, input byte_q_t data, input logic valid,
                                    input logic [6:0] addr, input logic [3:0] endp,
                                    input logic [10:0] frame,
                                    output logic relay, output byte_q_t bytes);
        logic [10:0] f;
        bytes = {};
        relay = valid && (data.size() <= DEPTH);
        if (!relay) return;
        if (pid[1:0] == PID_CLASS_DATA) begin
            if (data.size() < 2) relay = 1'b0;
            else for (int i = 0; i < data.size() - 2; i++) bytes.push_back(data[i]);
        end else if (pid[1:0] == PID_CLASS_TOKEN) begin
            f = (pid == PID_SOF) ? frame : {endp, addr};
            bytes.push_back(f[7:0]);
            bytes.push_back({crc5_ref(f), f[10:8]});
        end
    endfunction

    task automatic note_drop();
        if (exp_drops < CNT_MAX) exp_drops++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_pkt_start"}, tx_pkt_start, 0);
        check({tag, "_tx_pid"}, tx_pid, 0);
        check({tag, "_tx_data_avail"}, tx_data_avail, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic apply_reset();
        rx_pkt_start = 0; rx_pkt_end = 0; rx_pkt_valid = 0; rx_data_put = 0;
        tx_data_get = 0; tx_pkt_end = 0;
        reset = 1;
        step();
        reset = 0;
        exp_drops = 0;
    endtask

    task automatic drive_rx(input logic [3:0] pid, input byte_q_t data, input logic valid,
                            input logic [6:0] addr, input logic [3:0] endp, input logic [10:0] frame);
        rx_pkt_start = 1;
        step();
        rx_pkt_start = 0;
        foreach (data[i]) begin
            if ($urandom_range(0, 3) == 0) step();
            rx_data = data[i];
            rx_data_put = 1;
            step();
            rx_data_put = 0;
        end
        rx_pid = pid; rx_addr = addr; rx_endp = endp; rx_frame_num = frame;
        rx_pkt_valid = valid;
        rx_pkt_end = 1;
        step();
        rx_pkt_end = 0;
        rx_pkt_valid = 0;
    endtask

    task automatic expect_quiet();
        repeat (3) begin
            step();
            check("no_tx_pkt_start", tx_pkt_start, 0);
        end
        check("idle_after_drop", busy, 0);
    endtask

    task automatic tx_drain(input byte_q_t exp);
        int i = 0;
        int cycles = 0;
        while (i < exp.size()) begin
            if (cycles > 4 * DEPTH + 20) begin
                check("tx_drain_timeout", i, exp.size());
                break;
            end
            check("tx_data_avail", tx_data_avail, 1);
            check("tx_data", tx_data, exp[i]);
            if ($urandom_range(0, 3) != 0) begin
                tx_data_get = 1;
                step();
                tx_data_get = 0;
                i++;
            end else begin
                step();
            end
            cycles++;
        end
        check("avail_low_after_last", tx_data_avail, 0);
        tx_data_get = 1;
        step();
        tx_data_get = 0;
        check("get_without_avail", tx_data_avail, 0);
        check("busy_in_send", busy, 1);
    endtask

    task automatic interferer();
        step();
        rx_pkt_start = 1;
        step();
        rx_pkt_start = 0;
        for (int k = 0; k < 3; k++) begin
            rx_data = 8'($urandom);
            rx_data_put = 1;
            step();
        end
        rx_data_put = 0;
        rx_pid = PID_DATA0;
        rx_pkt_valid = 1;
        rx_pkt_end = 1;
        step();
        rx_pkt_end = 0;
        rx_pkt_valid = 0;
    endtask

    task automatic run_packet(input logic [3:0] pid, input byte_q_t data, input logic valid,
                              input logic [6:0] addr, input logic [3:0] endp, input logic [10:0] frame,
                              input logic exp_relay, input byte_q_t exp_bytes,
                              input logic interfere, input logic collide);
        drive_rx(pid, data, valid, addr, endp, frame);
        if (exp_relay) begin
            check("start_not_early", tx_pkt_start, 0);
            step();
            check("tx_pkt_start", tx_pkt_start, 1);
            check("tx_pid", tx_pid, pid);
            check("busy", busy, 1);
            step();
            check("start_one_cycle", tx_pkt_start, 0);
            check("tx_pid_held", tx_pid, pid);
            if (interfere) begin
                fork
                    tx_drain(exp_bytes);
                    interferer();
                join
                note_drop();
            end else begin
                tx_drain(exp_bytes);
            end
            rx_pkt_start = collide;
            tx_pkt_end = 1;
            step();
            rx_pkt_start = 0;
            tx_pkt_end = 0;
            check("idle_after_tx_end", busy, 0);
            check("avail_after_tx_end", tx_data_avail, 0);
            if (collide) begin
                note_drop();
                rx_data = 8'h5A;
                rx_data_put = 1;
                step();
                rx_data_put = 0;
                rx_pid = PID_DATA1;
                rx_pkt_valid = 1;
                rx_pkt_end = 1;
                step();
                rx_pkt_end = 0;
                rx_pkt_valid = 0;
                expect_quiet();
            end
        end else begin
            note_drop();
            expect_quiet();
        end
        check("drop_count", drop_count, exp_drops);
    endtask

    task automatic model_packet(input logic [3:0] pid, input byte_q_t data, input logic valid,
                                input logic [6:0] addr, input logic [3:0] endp, input logic [10:0] frame,
                                input logic interfere, input logic collide);
        logic    relay;
        byte_q_t bytes;
        predict(pid, data, valid, addr, endp, frame, relay, bytes);
        run_packet(pid, data, valid, addr, endp, frame, relay, bytes, interfere, collide && relay);
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q_t     none, d, kat;
        logic [3:0]  pid_tab [9];
        logic [3:0]  pid;
        int          len;

        pid_tab = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0, PID_DATA1,
                    PID_ACK, PID_NAK, PID_STALL};
        none = {};
        rx_pid = 0; rx_addr = 0; rx_endp = 0; rx_frame_num = 0; rx_data = 0;
        apply_reset();
        check_reset_outputs("por");

        // DATA0 with 4 payload bytes plus CRC16.
        model_packet(PID_DATA0, rand_bytes(6), 1, 0, 0, 0, 0, 0);
        // IN token, addr 0x15 endp 1.
        model_packet(PID_IN, none, 1, 7'h15, 4'h1, 0, 0, 0);
        // Published USB example: addr 0x15 endp 0xE carries CRC5 0b10111.
        kat = {8'h15, 8'hEF};
        run_packet(PID_OUT, none, 1, 7'h15, 4'hE, 0, 1, kat, 0, 0);
        model_packet(PID_SOF, none, 1, 0, 0, 11'h5A3, 0, 0);
        model_packet(PID_ACK, none, 1, 0, 0, 0, 0, 0);

        // Invalid packet then oversized packet from a clean count.
        apply_reset();
        model_packet(PID_DATA1, rand_bytes(10), 0, 0, 0, 0, 0, 0);
        model_packet(PID_DATA0, rand_bytes(80), 1, 0, 0, 0, 0, 0);
        check("two_drops", drop_count, 2);

        // Reset in the middle of a capture.
        rx_pkt_start = 1; step(); rx_pkt_start = 0;
        for (int k = 0; k < 3; k++) begin
            rx_data = 8'($urandom); rx_data_put = 1; step();
        end
        rx_data_put = 0;
        apply_reset();
        check_reset_outputs("rst_capture");
        model_packet(PID_DATA1, rand_bytes(5), 1, 0, 0, 0, 0, 0);

        // Buffer-size and length boundaries.
        model_packet(PID_DATA1, rand_bytes(DEPTH), 1, 0, 0, 0, 0, 0);
        model_packet(PID_DATA0, rand_bytes(DEPTH + 1), 1, 0, 0, 0, 0, 0);
        model_packet(PID_DATA0, rand_bytes(2), 1, 0, 0, 0, 0, 0);
        model_packet(PID_DATA0, rand_bytes(1), 1, 0, 0, 0, 0, 0);
        model_packet(PID_DATA1, none, 1, 0, 0, 0, 0, 0);

        // Overlapping rx packet while sending, and rx start colliding with tx end.
        model_packet(PID_DATA0, rand_bytes(10), 1, 0, 0, 0, 1, 0);
        model_packet(PID_DATA1, rand_bytes(4), 1, 0, 0, 0, 0, 1);

        // Reset in the middle of a send.
        d = rand_bytes(12);
        drive_rx(PID_DATA0, d, 1, 0, 0, 0);
        step(); step();
        check("pre_reset_avail", tx_data_avail, 1);
        tx_data_get = 1; step(); tx_data_get = 0;
        apply_reset();
        check_reset_outputs("rst_send");
        model_packet(PID_SETUP, none, 1, 7'($urandom), 4'($urandom), 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            pid = pid_tab[$urandom_range(0, 8)];
            len = (pid[1:0] == PID_CLASS_DATA) ? $urandom_range(0, DEPTH + 4) : 0;
            model_packet(pid, rand_bytes(len), ($urandom_range(0, 7) != 0),
                         7'($urandom), 4'($urandom), 11'($urandom),
                         0, ($urandom_range(0, 5) == 0));
        end

        // Saturation of the drop counter.
        for (int n = 0; n < CNT_MAX + 5; n++) begin
            rx_pkt_start = 1; step(); rx_pkt_start = 0;
            rx_pkt_valid = 0; rx_pkt_end = 1; step(); rx_pkt_end = 0;
            note_drop();
        end
        step();
        check("drop_count_saturated", drop_count, exp_drops);
        check("idle_after_saturation", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
